vx_tag_flush_ctrl: RTL

Sequencer that owns the write/address port of a bank's tag store and shares it between the bank pipeline (lookup/fill) and an internal line-by-line invalidation sweep. After reset it invalidates every line before admitting pipeline traffic. On an explicit flush request it drains in-flight pipeline ops, then sweeps all lines. It sits between the bank request pipeline and the tag access block, one instance per bank.

---
 rtl/vx_tag_flush_ctrl.sv | 129 ++++++++++++
 1 files changed

// File: rtl/vx_tag_flush_ctrl.sv
// rtl/vx_tag_flush_ctrl.sv - tag store port sequencer: reset/flush invalidation sweep and pipeline pass-through
// Owns the tag store write/address port; arbitrates between bank pipeline ops and line-by-line invalidation.
module vx_tag_flush_ctrl #(
  parameter int LINES_PER_BANK   = 64,
  parameter int LINE_ADDR_WIDTH  = 26,
  parameter int LINE_SELECT_BITS = (LINES_PER_BANK > 1) ? $clog2(LINES_PER_BANK) : 1,
  parameter int DRAIN_CYCLES     = 2
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       flush_req_valid,
  output logic                       flush_req_ready,
  output logic                       flush_done,
  output logic                       busy,
  input  logic                       pipe_valid,
  output logic                       pipe_ready,
  input  logic                       pipe_fill,
  input  logic [LINE_ADDR_WIDTH-1:0] pipe_addr,
  output logic [LINE_ADDR_WIDTH-1:0] tag_addr,
  output logic                       tag_fill,
  output logic                       tag_flush,
  output logic                       tag_lookup
);

  localparam int DCTR_BITS = (DRAIN_CYCLES > 0) ? $clog2(DRAIN_CYCLES + 1) : 1;
  localparam logic [LINE_SELECT_BITS-1:0] LAST_LINE = LINE_SELECT_BITS'(LINES_PER_BANK - 1);
  localparam logic [DCTR_BITS-1:0] LAST_DRAIN =
    DCTR_BITS'((DRAIN_CYCLES > 0) ? (DRAIN_CYCLES - 1) : 0);

  typedef enum logic [2:0] {
    ST_INIT  = 3'd0,
    ST_IDLE  = 3'd1,
    ST_DRAIN = 3'd2,
    ST_FLUSH = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

  state_e                      state_q, state_d;
  logic [LINE_SELECT_BITS-1:0] ctr_q, ctr_d;
  logic [DCTR_BITS-1:0]        dctr_q, dctr_d;

  logic flush_accept;
  logic sweeping;

  assign flush_accept = (state_q == ST_IDLE) && flush_req_valid;
  assign sweeping     = (state_q == ST_INIT) || (state_q == ST_FLUSH);

  always_comb begin
    state_d = state_q;
    ctr_d   = ctr_q;
    dctr_d  = dctr_q;
    unique case (state_q)
      ST_INIT, ST_FLUSH: begin
        if (ctr_q == LAST_LINE) begin
          ctr_d   = '0;
          state_d = (state_q == ST_INIT) ? ST_IDLE : ST_DONE;
        end else begin
          ctr_d = ctr_q + 1'b1;
        end
      end
      ST_IDLE: begin
        if (flush_accept) begin
          // An op issued in this same cycle is retired by the drain window.
          if (DRAIN_CYCLES > 0) begin
            state_d = ST_DRAIN;
            dctr_d  = '0;
          end else begin
            state_d = ST_FLUSH;
            ctr_d   = '0;
          end
        end
      end
      ST_DRAIN: begin
        if (dctr_q == LAST_DRAIN) begin
          state_d = ST_FLUSH;
          ctr_d   = '0;
          dctr_d  = '0;
        end else begin
          dctr_d = dctr_q + 1'b1;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_INIT;
        ctr_d   = '0;
        dctr_d  = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_INIT;
      ctr_q   <= '0;
      dctr_q  <= '0;
    end else begin
      state_q <= state_d;
      ctr_q   <= ctr_d;
      dctr_q  <= dctr_d;
    end
  end

  // Pure decode of state/ctr/pipe inputs so IDLE pass-through adds no latency.
  always_comb begin
    flush_req_ready = 1'b0;
    flush_done      = 1'b0;
    busy            = 1'b1;
    pipe_ready      = 1'b0;
    tag_addr        = LINE_ADDR_WIDTH'(ctr_q);
    tag_fill        = 1'b0;
    tag_flush       = 1'b0;
    tag_lookup      = 1'b0;
    if (sweeping) begin
      tag_flush = 1'b1;
    end else if (state_q == ST_IDLE) begin
      flush_req_ready = 1'b1;
      busy            = 1'b0;
      pipe_ready      = 1'b1;
      tag_addr        = pipe_addr;
      tag_fill        = pipe_valid && pipe_fill;
      tag_lookup      = pipe_valid && !pipe_fill;
    end else if (state_q == ST_DONE) begin
      flush_done = 1'b1;
    end
  end

endmodule
